stream_fifo: RTL

- Synchronous valid/ready stream FIFO, single clock domain.
- Standard buffering stage placed between the simulation stimulus driver and any IP under test, and between pipeline stages inside IP cores.
- First-word-fall-through: the head word is visible on m_data whenever m_valid=1.
- Provides occupancy count, programmable almost-full/almost-empty flags and a synchronous flush.

---
 rtl/stream_fifo.sv | 78 +++++++
 1 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy count, almost-full/empty
// flags and synchronous flush. Single clock domain, async active-low reset.
module stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AFULL_TH   = 6,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         m_valid,
    output logic [DATA_WIDTH-1:0]        m_data,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop;

    assign s_ready      = (count_q != CW'(DEPTH));
    assign m_valid      = (count_q != '0);
    assign m_data       = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= s_data;
    end

endmodule
